dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single 16-bit, byte-addressed, big-endian data memory between two requesters: port C (CPU load/store stage) and port D (DMA/debug loader).
- Sits between the requesters and the data memory. Drives its address, write data, MemWrite and MemRead, and samples its combinational ReadData.
- Fixed priority to C, with a starvation guard for D. Range-checks every access and returns registered read data with a valid strobe.

Parameters:
- ADDR_W, 16, address width on all ports.
- DATA_W, 16, data width (two bytes per access).
- MEM_BYTES, 64, memory depth in bytes. Legal access address range is 0..MEM_BYTES-2.
- MAX_WAIT, 4, consecutive denied cycles after which D overrides C.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  reset; synchronous, active-low.
- C_Req  in  1  port C request; held with fields stable until C_Ready.
- C_We  in  1  port C write (1) / read (0).
- C_Addr  in  ADDR_W  port C byte address.
- C_WD  in  DATA_W  port C write data; [15:8] goes to Addr, [7:0] to Addr+1.
- C_Ready  out  1  port C request accepted this cycle (combinational).
- C_RValid  out  1  port C read data valid (registered, 1 cycle after accept).
- C_RData  out  DATA_W  port C read data.
- C_Err  out  1  port C out-of-range access; pulses together with the completion.
- D_Req, D_We, D_Addr, D_WD, D_Ready, D_RValid, D_RData, D_Err: same as the C ports, for port D.
- M_Adresa  out  ADDR_W  memory address.
- M_WD  out  DATA_W  memory write data.
- M_MemWrite  out  1  memory write enable.
- M_MemRead  out  1  memory read enable.
- M_ReadData  in  DATA_W  memory combinational read data.

Behaviour:
- Reset (Rst_n=0 at a rising edge):
  - Registered outputs clear: *_RValid=0, *_RData=0, *_Err=0.
  - Wait counter clears to 0; last-grant register clears to C.
  - While Rst_n=0, all combinational outputs are forced to 0: Ready, M_MemWrite, M_MemRead.
- Reset mid-operation: a read accepted in the cycle before reset produces no RValid. A write whose accept edge coincides with reset is blocked, because M_MemWrite is forced low.
- Grant, evaluated combinationally each cycle:
  - D wins if D_Req=1 and wait_cnt>=MAX_WAIT.
  - Otherwise C wins if C_Req=1.
  - Otherwise D wins if D_Req=1.
  - Exactly one Ready is high per cycle, at most.
- Memory drive: the granted port's Addr/WD go to M_Adresa/M_WD. M_MemWrite = granted & We & in_range. M_MemRead = granted & ~We & in_range. With no grant, memory outputs are 0.
- in_range = Addr <= MEM_BYTES-2. Odd addresses are legal; no alignment requirement.
- Write latency: the memory commits at the accept edge. A read accepted in the following cycle returns the new data.
- Read latency: 1 cycle. On the accept edge, RData <= M_ReadData and RValid <= 1 for the granted port. RValid and Err are single-cycle pulses. RData holds its value between reads.
- Out-of-range access:
  - Accepted (Ready=1), but no memory enable is asserted.
  - Next cycle: Err=1. For a read, also RValid=1 with RData=0.
  - Writes are silently dropped apart from the Err pulse.
- wait_cnt, saturating at MAX_WAIT:
  - Increments when D_Req=1 and D is not granted.
  - Clears when D is granted or D_Req=0.
- Back-to-back: a port may be accepted on consecutive cycles. A new accept is allowed while the previous read's RValid is high.
- Simultaneous C and D requests to the same address: serialised by grant order. No merging.

Decomposition:
- Shared package dmem_pkg holds:
  - MEM_BYTES, DATA_W, ADDR_W defaults.
  - Port-select encoding: PORT_C=0, PORT_D=1.
  - A req_t bundle (req, we, addr, wd) and a rsp_t bundle (ready, rvalid, rdata, err).
- One natural sub-module: dmem_starve_ctr, the saturating wait counter with clear/increment and an expired flag.

Test Plan:
- Reset: hold Rst_n=0 with both Req=1 -> all Ready, RValid, Err and M_* enables are 0. After release, wait_cnt=0.
- C write then read: C write Addr=0x10, WD=0xABCD -> C_Ready=1 and M_MemWrite=1 that cycle. C read Addr=0x10 next cycle -> C_RValid=1, C_RData=0xABCD one cycle after accept.
- Contention and starvation: C_Req and D_Req held high for 8 cycles -> C granted cycles 0-3, D granted cycle 4 (wait_cnt=4), C granted cycles 5-7. D_RValid fires in cycle 5 for a D read.
- Odd address: D read Addr=0x0B after bytes 0x0B=0x12 and 0x0C=0x34 have been written -> D_RData=0x1234, D_Err=0.
- Out of range: C write Addr=63 -> C_Ready=1, M_MemWrite=0, C_Err pulse next cycle. C read Addr=0x40 -> C_RValid=1, C_RData=0, C_Err=1.
- Reset mid-read: C read accepted, Rst_n=0 at the next edge -> C_RValid stays 0 and C_RData=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Port select, request and response bundles.
package dmem_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int MEM_BYTES = 64;
  localparam int MAX_WAIT  = 4;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
  } req_t;

  typedef struct packed {
    logic              ready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_t;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating wait counter for the low-priority port.
// expired goes high once the count reaches MAX_WAIT.
module dmem_starve_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int W = $clog2(MAX_WAIT + 1);

  logic [W-1:0] cnt;

  assign expired = (cnt >= W'(MAX_WAIT));

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the byte-addressed data memory.
// C has priority; D overrides after MAX_WAIT denied cycles.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MAX_WAIT = dmem_pkg::MAX_WAIT
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              C_Req,
  input  logic              C_We,
  input  logic [ADDR_W-1:0] C_Addr,
  input  logic [DATA_W-1:0] C_WD,
  output logic              C_Ready,
  output logic              C_RValid,
  output logic [DATA_W-1:0] C_RData,
  output logic              C_Err,
  input  logic              D_Req,
  input  logic              D_We,
  input  logic [ADDR_W-1:0] D_Addr,
  input  logic [DATA_W-1:0] D_WD,
  output logic              D_Ready,
  output logic              D_RValid,
  output logic [DATA_W-1:0] D_RData,
  output logic              D_Err,
  output logic [ADDR_W-1:0] M_Adresa,
  output logic [DATA_W-1:0] M_WD,
  output logic              M_MemWrite,
  output logic              M_MemRead,
  input  logic [DATA_W-1:0] M_ReadData
);

  req_t c_req, d_req, g_req;
  rsp_t c_rsp, d_rsp;

  logic gnt_c, gnt_d, granted, sel, ok, expired;

  logic              c_rv, d_rv, c_er, d_er;
  logic [DATA_W-1:0] c_rd, d_rd;

  assign c_req = '{C_Req, C_We, C_Addr, C_WD};
  assign d_req = '{D_Req, D_We, D_Addr, D_WD};

  // Starved D beats C; otherwise C first, then D.
  always_comb begin
    gnt_c = 1'b0;
    gnt_d = 1'b0;
    if (Rst_n) begin
      if (d_req.req && expired) begin
        gnt_d = 1'b1;
      end else if (c_req.req) begin
        gnt_c = 1'b1;
      end else if (d_req.req) begin
        gnt_d = 1'b1;
      end
    end
  end

  assign granted = gnt_c | gnt_d;
  assign sel     = gnt_d ? PORT_D : PORT_C;
  assign g_req   = (sel == PORT_D) ? d_req : c_req;
  assign ok      = (g_req.addr <= ADDR_W'(MEM_BYTES - 2));

  always_comb begin
    M_Adresa   = '0;
    M_WD       = '0;
    M_MemWrite = 1'b0;
    M_MemRead  = 1'b0;
    if (granted) begin
      M_Adresa   = g_req.addr;
      M_WD       = g_req.wd;
      M_MemWrite = g_req.we & ok;
      M_MemRead  = ~g_req.we & ok;
    end
  end

  dmem_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .clr     (~D_Req | gnt_d),
    .inc     (D_Req & ~gnt_d),
    .expired (expired)
  );

  // Out-of-range reads complete with zero data plus the error pulse.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      c_rv <= 1'b0;
      c_er <= 1'b0;
      c_rd <= '0;
      d_rv <= 1'b0;
      d_er <= 1'b0;
      d_rd <= '0;
    end else begin
      c_rv <= gnt_c & ~C_We;
      c_er <= gnt_c & ~ok;
      d_rv <= gnt_d & ~D_We;
      d_er <= gnt_d & ~ok;
      if (gnt_c && !C_We) begin
        c_rd <= ok ? M_ReadData : '0;
      end
      if (gnt_d && !D_We) begin
        d_rd <= ok ? M_ReadData : '0;
      end
    end
  end

  assign c_rsp = '{gnt_c, c_rv, c_rd, c_er};
  assign d_rsp = '{gnt_d, d_rv, d_rd, d_er};

  assign C_Ready  = c_rsp.ready;
  assign C_RValid = c_rsp.rvalid;
  assign C_RData  = c_rsp.rdata;
  assign C_Err    = c_rsp.err;
  assign D_Ready  = d_rsp.ready;
  assign D_RValid = d_rsp.rvalid;
  assign D_RData  = d_rsp.rdata;
  assign D_Err    = d_rsp.err;

endmodule
